// File: rtl/led_view_sched.sv
`default_nettype none
// ============================================================================
// Module   : led_view_sched
// Brief    : Debounced key selection of ax/bx/cx/dx with manual hold or
//            auto-scan, nibble-multiplexed onto a 4-LED display.
// Revision : 1.0
// ============================================================================
module led_view_sched #(
    parameter int DEB_CYCLES   = 4,
    parameter int DWELL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    input  logic [7:0] ax,
    input  logic [7:0] bx,
    input  logic [7:0] cx,
    input  logic [7:0] dx,
    output logic [3:0] led_out,
    output logic [1:0] sel,
    output logic       nib_hi,
    output logic       auto_mode
);

    localparam int                 c_deb_w   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_deb_w-1:0] c_deb_max = c_deb_w'(DEB_CYCLES - 1);
    localparam int                 c_dw_w    = $clog2(DWELL_CYCLES);
    localparam logic [c_dw_w-1:0]  c_dw_max  = c_dw_w'(DWELL_CYCLES - 1);

    localparam logic [0:0] c_st_manual = 1'b0;
    localparam logic [0:0] c_st_auto   = 1'b1;

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [3:0]        w_deb;
    logic [3:0]        r_deb_d;
    logic [3:0]        w_press;
    logic              w_hit;
    logic [1:0]        w_key;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [1:0]        r_sel;
    logic [1:0]        w_sel_nxt;
    logic              r_nib;
    logic              w_nib_nxt;
    logic [c_dw_w-1:0] r_dwell;
    logic [c_dw_w-1:0] w_dwell_nxt;
    logic              w_term;
    logic [7:0]        w_reg;
    logic [3:0]        r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb_d <= '1;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
            r_deb_d <= w_deb;
        end
    end

    // A level change is accepted only after DEB_CYCLES consecutive mismatches.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_deb
            logic [c_deb_w-1:0] r_cnt;
            logic               r_lvl;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b1;
                end else if (r_sync2[k] != r_lvl) begin
                    if (r_cnt == c_deb_max) begin
                        r_lvl <= r_sync2[k];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign w_deb[k] = r_lvl;
        end
    endgenerate

    assign w_press = r_deb_d & ~w_deb;

    always_comb begin
        w_hit = 1'b0;
        w_key = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_press[i]) begin
                w_hit = 1'b1;
                w_key = 2'(i);
            end
        end
    end

    assign w_term = (r_dwell == c_dw_max);

    always_comb begin
        case (r_sel)
            2'd0:    w_reg = ax;
            2'd1:    w_reg = bx;
            2'd2:    w_reg = cx;
            default: w_reg = dx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_manual;
            r_sel   <= 2'd0;
            r_nib   <= 1'b0;
            r_dwell <= '0;
            r_led   <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_nib   <= w_nib_nxt;
            r_dwell <= w_dwell_nxt;
            r_led   <= r_nib ? w_reg[7:4] : w_reg[3:0];
        end
    end

    // A key press restarts the dwell phase and beats a coincident terminal count.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_nib_nxt   = r_nib;
        w_dwell_nxt = r_dwell + 1'b1;
        if (w_hit) begin
            w_nib_nxt   = 1'b0;
            w_dwell_nxt = '0;
            if (r_state == c_st_manual) begin
                if (w_key == r_sel) begin
                    w_state_nxt = c_st_auto;
                end else begin
                    w_sel_nxt = w_key;
                end
            end else begin
                w_state_nxt = c_st_manual;
                w_sel_nxt   = w_key;
            end
        end else if (w_term) begin
            w_dwell_nxt = '0;
            w_nib_nxt   = ~r_nib;
            if ((r_state == c_st_auto) && r_nib) begin
                w_sel_nxt = r_sel + 2'd1;
            end
        end
    end

    always_comb begin
        auto_mode = (r_state == c_st_auto);
        sel       = r_sel;
        nib_hi    = r_nib;
        led_out   = r_led;
    end

endmodule
`default_nettype wire
